frame_buffer: RTL
=================

Name: frame_buffer

Overview:
- Parametrised frame buffer for the framing/encoding path.
- Captures a burst of words while din_valid is high, then replays them in arrival order in a fixed output frame: LEFT_PAD pad cycles, each word held HOLD cycles, then RIGHT_PAD pad cycles.
- Over the single-width byte version it adds:
  - configurable width, depth, padding and hold;
  - an input ready, overflow detection and a frame length output;
  - separate registered receive-done and transmit-done pulses;
  - an output valid qualifier.

Parameters:
DATA_WIDTH, 8, width of din/dout words
DEPTH, 20, maximum words stored per frame (>=1)
LEN_WIDTH, 5, width of frame_len; must hold DEPTH
LEFT_PAD, 80, pad cycles before first word (>=1)
RIGHT_PAD, 16, pad cycles after last word (>=1)
HOLD, 8, cycles each word is held on dout (>=1)
CNT_WIDTH, 7, width of the phase counter; must hold max(LEFT_PAD, RIGHT_PAD, HOLD)
PAD_VALUE, 0, dout value whenever dout_valid=0

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
din  input  DATA_WIDTH  input word
din_valid  input  1  word present; frame ends on first cycle low after ≥1 accepted-or-dropped word
din_ready  output  1  high in IDLE and RECEIVING
dout  output  DATA_WIDTH  replayed word, or PAD_VALUE
dout_valid  output  1  high while dout carries a frame word
rx_done  output  1  one-cycle pulse, first cycle of LEFT_PAD
tx_done  output  1  one-cycle pulse, first cycle of RIGHT_PAD
busy  output  1  high in any state except IDLE
overflow  output  1  sticky; words were dropped in the current frame
frame_len  output  LEN_WIDTH  words stored in current frame

Behaviour:
- Reset (async, reset_n low): state=IDLE; all counters and pointers 0; frame_len=0; overflow=0; rx_done=tx_done=0; dout=PAD_VALUE; dout_valid=0; busy=0; din_ready=1. Buffer contents are don't-care.
  - Reset asserted mid-frame aborts the frame immediately with no done pulses.
- States: IDLE, RECEIVING, LEFT_PAD, TRANSFER, RIGHT_PAD.
- IDLE:
  - din_valid=1 at an edge: din written to slot 0, frame_len=1, overflow cleared, go RECEIVING.
  - Otherwise stay in IDLE.
- RECEIVING:
  - din_valid=1 and frame_len<DEPTH: store at slot frame_len, frame_len+1.
  - din_valid=1 and frame_len==DEPTH: word dropped, overflow set (stays set until the next frame starts in IDLE).
  - din_valid=0: go LEFT_PAD, counter=0.
- LEFT_PAD:
  - Exactly LEFT_PAD cycles.
  - rx_done=1 in the first of them only.
  - Then go TRANSFER, read pointer=0, counter=0.
- TRANSFER:
  - dout=buffer[rd], dout_valid=1.
  - Counter advances each cycle; at HOLD-1 it wraps to 0 and rd increments.
  - When the word at rd=frame_len-1 completes its HOLD cycles, go RIGHT_PAD.
  - Total TRANSFER duration = frame_len*HOLD cycles.
- RIGHT_PAD:
  - Exactly RIGHT_PAD cycles.
  - tx_done=1 in the first only.
  - Then go IDLE, frame_len=0; overflow keeps its value.
- dout/dout_valid/din_ready/busy are decoded from registered state, with no added latency. rx_done/tx_done are registered.
- din_valid in LEFT_PAD, TRANSFER or RIGHT_PAD is ignored (din_ready=0), not stored, and does not set overflow.
- Back-to-back frames: din_valid high in the first IDLE cycle after RIGHT_PAD is accepted as a new frame's first word.
- Latency: the first frame word appears on dout LEFT_PAD cycles after the cycle in which din_valid is first seen low.

Test Plan:
- Defaults, din=A1,B2,C3 on 3 consecutive edges, then din_valid=0:
  - rx_done pulses once.
  - 80 cycles of dout=00, dout_valid=0.
  - Then A1 for 8 cycles, B2 for 8, C3 for 8, each with dout_valid=1.
  - tx_done pulses once, followed by 16 pad cycles.
  - busy falls; frame_len=3 throughout, 0 in IDLE.
- Overflow: 22 consecutive words 01..16 (hex):
  - frame_len=20; overflow=1 from the edge storing word 21.
  - Replay is 01..14 only, 160 valid cycles.
  - overflow clears on the next frame's first word.
- din_valid toggling with din=FF during LEFT_PAD and TRANSFER of a 2-word frame (11,22) -> din_ready=0; replay still 11,22; frame_len=2; overflow=0.
- reset_n pulsed low mid-TRANSFER (second word) -> outputs at reset values asynchronously, no tx_done; a following 1-word frame 5A replays correctly.
- Back-to-back: new frame din=33 in the first IDLE cycle after RIGHT_PAD -> accepted; the full second frame replays 33.
- DATA_WIDTH=16, DEPTH=4, LEFT_PAD=1, RIGHT_PAD=1, HOLD=1, frame BEEF,CAFE:
  - rx_done, then 1 pad cycle.
  - BEEF, CAFE on consecutive cycles.
  - tx_done, 1 pad cycle, then IDLE.

Source files
------------

// File: rtl/frame_buffer.sv
// Frame buffer: captures a burst of words, then replays them framed by left/right
// padding, each word held for a fixed number of cycles.
module frame_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 20,
    parameter int                    LEN_WIDTH  = 5,
    parameter int                    LEFT_PAD   = 80,
    parameter int                    RIGHT_PAD  = 16,
    parameter int                    HOLD       = 8,
    parameter int                    CNT_WIDTH  = 7,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_din_valid,
    output logic                  o_din_ready,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_rx_done,
    output logic                  o_tx_done,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [LEN_WIDTH-1:0]  o_frame_len
);

    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LEN_WIDTH-1:0] DEPTH_L    = LEN_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LEFT_LAST  = CNT_WIDTH'(LEFT_PAD - 1);
    localparam logic [CNT_WIDTH-1:0] RIGHT_LAST = CNT_WIDTH'(RIGHT_PAD - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECEIVING,
        S_LEFT_PAD,
        S_TRANSFER,
        S_RIGHT_PAD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_next;
    logic [LEN_WIDTH-1:0]    r_rd;
    logic [LEN_WIDTH-1:0]    w_rd_next;
    logic [LEN_WIDTH-1:0]    r_frame_len;
    logic [LEN_WIDTH-1:0]    w_frame_len_next;
    logic                    r_overflow;
    logic                    w_overflow_next;
    logic                    r_rx_done;
    logic                    w_rx_done_next;
    logic                    r_tx_done;
    logic                    w_tx_done_next;
    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rd_next        = r_rd;
        w_frame_len_next = r_frame_len;
        w_overflow_next  = r_overflow;
        w_rx_done_next   = 1'b0;
        w_tx_done_next   = 1'b0;
        w_wr_en          = 1'b0;
        w_wr_addr        = r_frame_len[ADDR_WIDTH-1:0];

        case (r_state)
            S_IDLE: begin
                if (i_din_valid) begin
                    w_wr_en          = 1'b1;
                    w_wr_addr        = '0;
                    w_frame_len_next = LEN_WIDTH'(1);
                    w_overflow_next  = 1'b0;
                    w_state_next     = S_RECEIVING;
                end
            end

            S_RECEIVING: begin
                if (i_din_valid) begin
                    if (r_frame_len < DEPTH_L) begin
                        w_wr_en          = 1'b1;
                        w_frame_len_next = r_frame_len + 1'b1;
                    end else begin
                        w_overflow_next  = 1'b1;
                    end
                end else begin
                    w_state_next   = S_LEFT_PAD;
                    w_cnt_next     = '0;
                    w_rx_done_next = 1'b1;
                end
            end

            S_LEFT_PAD: begin
                if (r_cnt == LEFT_LAST) begin
                    w_state_next = S_TRANSFER;
                    w_cnt_next   = '0;
                    w_rd_next    = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end

            S_TRANSFER: begin
                // Word boundary: either advance to the next slot or close the frame.
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next = '0;
                    if (r_rd == r_frame_len - 1'b1) begin
                        w_state_next   = S_RIGHT_PAD;
                        w_tx_done_next = 1'b1;
                    end else begin
                        w_rd_next      = r_rd + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_RIGHT_PAD: begin
                if (r_cnt == RIGHT_LAST) begin
                    w_state_next     = S_IDLE;
                    w_cnt_next       = '0;
                    w_rd_next        = '0;
                    w_frame_len_next = '0;
                end else begin
                    w_cnt_next       = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_frame_len <= '0;
            r_overflow  <= 1'b0;
            r_rx_done   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rd        <= w_rd_next;
            r_frame_len <= w_frame_len_next;
            r_overflow  <= w_overflow_next;
            r_rx_done   <= w_rx_done_next;
            r_tx_done   <= w_tx_done_next;
        end
    end

    // Read is prefetched with the next read pointer so the registered RAM output
    // lines up with r_rd in TRANSFER without adding a cycle of latency.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_din;
        end
        r_rd_data <= r_mem[w_rd_next[ADDR_WIDTH-1:0]];
    end

    assign o_dout_valid = (r_state == S_TRANSFER);
    assign o_dout       = o_dout_valid ? r_rd_data : PAD_VALUE;
    assign o_din_ready  = (r_state == S_IDLE) || (r_state == S_RECEIVING);
    assign o_busy       = (r_state != S_IDLE);
    assign o_rx_done    = r_rx_done;
    assign o_tx_done    = r_tx_done;
    assign o_overflow   = r_overflow;
    assign o_frame_len  = r_frame_len;

endmodule
